// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared indices, defaults and hold-phase type for the synth parameter bank
package synth_pkg;

   localparam int P_AMP     = 0;
   localparam int P_ATTACK  = 1;
   localparam int P_DECAY   = 2;
   localparam int P_SUSTAIN = 3;
   localparam int P_RELEASE = 4;
   localparam int P_OCTAVE  = 5;

   localparam int NUM_SYNTH_PARAMS = 6;

   // Param 0 sits in the LSBs: amp, attack, decay, sustain, release, octave.
   localparam logic [NUM_SYNTH_PARAMS*8-1:0] SYNTH_PARAM_DEFAULTS =
      {8'd4, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255};

   typedef enum logic {PH_DELAY = 1'b0, PH_RATE = 1'b1} hold_phase_e;

endpackage

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - key edge detection with hold-to-auto-repeat timer
// Auto-repeat is built only when PARAM_BANK_AUTOREPEAT_EN is defined.
module key_repeat
   import synth_pkg::*;
#(
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   input  logic clear,
   output logic step_up,
   output logic step_down
);

   logic up, down, inc_q, dec_q, edge_up, edge_down;

   assign up        = inc & ~dec;
   assign down      = dec & ~inc;
   assign edge_up   = up & ~inc_q;
   assign edge_down = down & ~dec_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inc_q <= 1'b0;
         dec_q <= 1'b0;
      end else begin
         inc_q <= inc;
         dec_q <= dec;
      end
   end

`ifdef PARAM_BANK_AUTOREPEAT_EN
   localparam int CW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);

   logic [CW-1:0] cnt, limit;
   logic          holding, hold_up, held, rep;
   hold_phase_e   phase;

   assign held  = hold_up ? up : down;
   assign limit = (phase == PH_DELAY) ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_RATE - 1);
   // Level is checked on the same edge, so a release cancels a due repeat.
   assign rep   = holding & held & ~clear & (cnt == limit);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         holding <= 1'b0;
         hold_up <= 1'b0;
         phase   <= PH_DELAY;
         cnt     <= '0;
      end else if (clear || !(up || down)) begin
         holding <= 1'b0;
         cnt     <= '0;
      end else if (edge_up || edge_down) begin
         holding <= 1'b1;
         hold_up <= edge_up;
         phase   <= PH_DELAY;
         cnt     <= '0;
      end else if (holding) begin
         if (!held) begin
            holding <= 1'b0;
            cnt     <= '0;
         end else if (rep) begin
            phase <= PH_RATE;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign step_up   = edge_up | (rep & hold_up);
   assign step_down = edge_down | (rep & ~hold_up);
`else
   logic unused_clear;

   assign unused_clear = clear;
   assign step_up      = edge_up;
   assign step_down    = edge_down;
`endif

endmodule

// File: rtl/synth_param_bank.sv
// rtl/synth_param_bank.sv - saturating synth parameter register bank with load and change strobe
// Auto-repeat of held keys is enabled by PARAM_BANK_AUTOREPEAT_EN.
module synth_param_bank
   import synth_pkg::*;
#(
   parameter int NUM_PARAMS = 6,
   parameter int WIDTH = 8,
   parameter int STEP = 1,
   parameter logic [NUM_PARAMS*WIDTH-1:0] DEFAULTS = SYNTH_PARAM_DEFAULTS,
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE = 5_000_000,
   localparam int SW = $clog2(NUM_PARAMS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [SW-1:0]               sel,
   input  logic                        inc,
   input  logic                        dec,
   input  logic                        load,
   input  logic [WIDTH-1:0]            load_value,
   output logic [NUM_PARAMS*WIDTH-1:0] params,
   output logic [WIDTH-1:0]            sel_value,
   output logic                        at_min,
   output logic                        at_max,
   output logic                        changed
);

   localparam logic [WIDTH-1:0] MAX    = '1;
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   logic [WIDTH-1:0] bank [NUM_PARAMS];
   logic [WIDTH-1:0] cur, wr_val;
   logic [SW-1:0]    sel_q;
   logic             sel_vld, sel_ok, sel_chg, step_up, step_down, wr_en;

   assign sel_ok    = (int'(sel) < NUM_PARAMS);
   assign cur       = sel_ok ? bank[sel] : '0;
   assign sel_value = cur;
   assign at_min    = (cur == '0);
   assign at_max    = (cur == MAX);
   // sel_vld keeps the first cycle after reset from looking like a selector move.
   assign sel_chg   = sel_vld & (sel != sel_q);

   for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_flat
      assign params[g*WIDTH +: WIDTH] = bank[g];
   end

   key_repeat #(
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
   ) u_key_repeat (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc),
      .dec      (dec),
      .clear    (load | sel_chg),
      .step_up  (step_up),
      .step_down(step_down)
   );

   always_comb begin
      wr_en  = 1'b0;
      wr_val = cur;
      if (sel_ok) begin
         if (load) begin
            wr_en  = 1'b1;
            wr_val = load_value;
         end else if (step_up) begin
            wr_en  = 1'b1;
            wr_val = (cur > MAX - STEP_W) ? MAX : cur + STEP_W;
         end else if (step_down) begin
            wr_en  = 1'b1;
            wr_val = (cur < STEP_W) ? '0 : cur - STEP_W;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_PARAMS; i++) bank[i] <= DEFAULTS[i*WIDTH +: WIDTH];
         changed <= 1'b0;
         sel_q   <= '0;
         sel_vld <= 1'b0;
      end else begin
         sel_q   <= sel;
         sel_vld <= 1'b1;
         changed <= wr_en & (wr_val != cur);
         if (wr_en) bank[sel] <= wr_val;
      end
   end

endmodule

// File: tb/tb_synth_param_bank.sv
// tb/tb_synth_param_bank.sv - directed self-checking bench for synth_param_bank
module tb_synth_param_bank;

   logic        clk, reset, inc, dec, load, changed, at_min, at_max;
   logic [2:0]  sel;
   logic [7:0]  load_value, sel_value;
   logic [47:0] params, exp_p;
   int          checks = 0;
   int          failures = 0;

   localparam logic [47:0] DEF = 48'h04_FF_FF_00_FF_FF;

`ifdef PARAM_BANK_AUTOREPEAT_EN
   localparam logic [7:0] REP20 = 8'd12;
   localparam logic [7:0] REP12 = 8'd6;
`else
   localparam logic [7:0] REP20 = 8'd3;
   localparam logic [7:0] REP12 = 8'd3;
`endif

   synth_param_bank #(
      .NUM_PARAMS  (6),
      .WIDTH       (8),
      .STEP        (3),
      .REPEAT_DELAY(10),
      .REPEAT_RATE (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sel       (sel),
      .inc       (inc),
      .dec       (dec),
      .load      (load),
      .load_value(load_value),
      .params    (params),
      .sel_value (sel_value),
      .at_min    (at_min),
      .at_max    (at_max),
      .changed   (changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      reset = 1'b0; sel = 3'd0; inc = 1'b0; dec = 1'b0; load = 1'b0; load_value = 8'h00;
      exp_p = DEF;
      tick(3);
      chk("reset_held_params", params, DEF);
      reset = 1'b1;
      tick(1);
      chk("reset_params", params, exp_p);
      chk("reset_changed", changed, 0);
      sel = 3'd5; #1;
      chk("octave_value", sel_value, 8'd4);
      chk("octave_at_min", at_min, 0);
      chk("octave_at_max", at_max, 0);

      sel = 3'd0; tick(1);
      inc = 1'b1; tick(1); inc = 1'b0;
      chk("sat_max_value", sel_value, 8'd255);
      chk("sat_max_at_max", at_max, 1);
      chk("sat_max_changed", changed, 0);
      dec = 1'b1; tick(1); dec = 1'b0;
      chk("dec_value", sel_value, 8'd252);
      chk("dec_changed", changed, 1);
      tick(1);
      chk("dec_changed_drop", changed, 0);
      exp_p[7:0] = 8'd252;

      sel = 3'd7; #1;
      chk("oob_value", sel_value, 8'd0);
      chk("oob_at_min", at_min, 1);
      chk("oob_at_max", at_max, 0);
      load = 1'b1; load_value = 8'h11; inc = 1'b1; tick(1); load = 1'b0; inc = 1'b0;
      chk("oob_params", params, exp_p);
      chk("oob_changed", changed, 0);

      sel = 3'd2; tick(1);
      inc = 1'b1; tick(1);
      chk("hold_first_step", sel_value, 8'd3);
      chk("hold_first_changed", changed, 1);
      tick(19); inc = 1'b0;
      chk("hold_repeat_value", sel_value, REP20);
      tick(1);

      load = 1'b1; load_value = 8'd2; tick(1); load = 1'b0;
      chk("load_value", sel_value, 8'd2);
      chk("load_changed", changed, 1);
      dec = 1'b1; tick(1); dec = 1'b0;
      chk("sat_min_value", sel_value, 8'd0);
      chk("sat_min_changed", changed, 1);
      dec = 1'b1; tick(1); dec = 1'b0;
      chk("sat_min_again", sel_value, 8'd0);
      chk("sat_min_no_pulse", changed, 0);
      chk("sat_min_at_min", at_min, 1);
      inc = 1'b1; dec = 1'b1; tick(30);
      chk("both_held_value", sel_value, 8'd0);
      inc = 1'b0; dec = 1'b0; tick(1);
      exp_p[23:16] = 8'd0;
      chk("both_released_params", params, exp_p);

      sel = 3'd1; tick(1);
      dec = 1'b1; tick(5);
      chk("selhold_first", params[15:8], 8'd252);
      sel = 3'd3; tick(20);
      exp_p[15:8] = 8'd252;
      chk("selhold_frozen", params, exp_p);
      dec = 1'b0; tick(1);
      dec = 1'b1; tick(1); dec = 1'b0;
      chk("selhold_repress", sel_value, 8'd252);
      exp_p[31:24] = 8'd252;
      tick(1);

      inc = 1'b1; load = 1'b1; load_value = 8'h80; tick(1); load = 1'b0;
      chk("load_edge_value", sel_value, 8'h80);
      chk("load_edge_changed", changed, 1);
      tick(15); inc = 1'b0;
      chk("load_no_repeat", sel_value, 8'h80);
      exp_p[31:24] = 8'h80;
      chk("load_params", params, exp_p);

      sel = 3'd2; tick(1);
      inc = 1'b1; tick(12);
      chk("prereset_value", sel_value, REP12);
      reset = 1'b0; #1;
      chk("midhold_reset_params", params, DEF);
      chk("midhold_reset_changed", changed, 0);
      tick(3);
      reset = 1'b1; tick(1);
      chk("postreset_step", sel_value, 8'd3);
      chk("postreset_changed", changed, 1);
      exp_p = DEF;
      exp_p[23:16] = 8'd3;
      chk("postreset_params", params, exp_p);
      inc = 1'b0; tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
